// File: rtl/zx_video_pkg.sv
// Shared ZX Spectrum screen geometry, attribute layout and fetch FSM state type.
package zx_video_pkg;

    localparam int ZX_W = 256;
    localparam int ZX_H = 192;
    localparam logic [12:0] ATTR_BASE = 13'h1800;

    // Attribute byte layout: ink[2:0], paper[5:3], BRIGHT[6], FLASH[7]
    localparam int ATTR_INK_LSB   = 0;
    localparam int ATTR_PAPER_LSB = 3;
    localparam int ATTR_BRIGHT    = 6;
    localparam int ATTR_FLASH     = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_PIX  = 2'd1,
        RD_ATTR = 2'd2,
        LATCH   = 2'd3
    } fetch_state_t;

    // Bitmap byte address: the Spectrum interleaves thirds, character rows and pixel rows.
    function automatic logic [12:0] zx_pix_addr(input logic [7:0] zy, input logic [4:0] col);
        return {zy[7:6], zy[2:0], zy[5:3], col};
    endfunction

    // Attribute byte address: one byte per 8x8 character cell, row-major after the bitmap.
    function automatic logic [12:0] zx_attr_addr(input logic [7:0] zy, input logic [4:0] col);
        return ATTR_BASE + {3'b000, zy[7:3], col};
    endfunction

endpackage

// File: rtl/zx_attr_colour.sv
// Turns one bitmap bit plus its cell attribute into channel levels at CBITS resolution.
module zx_attr_colour import zx_video_pkg::*; #(
    parameter int CBITS = 4
) (
    input  logic [7:0]       attr,
    input  logic             pix,
    input  logic             flash_phase,
    output logic [CBITS-1:0] red,
    output logic [CBITS-1:0] green,
    output logic [CBITS-1:0] blue
);

    localparam logic [CBITS-1:0] LVL_FULL = {CBITS{1'b1}};
    // Normal intensity: two ones at the top, zeros below (4 bits -> 4'hC).
    localparam logic [CBITS-1:0] LVL_NORM = ~(LVL_FULL >> 2);

    logic             ink_sel_s;
    logic [2:0]       grb_s;
    logic [CBITS-1:0] lvl_s;

    // Choose ink or paper (FLASH swaps them in the odd phase), then scale to the channel level.
    always_comb begin
        ink_sel_s = pix ^ (attr[ATTR_FLASH] & flash_phase);
        if (ink_sel_s) begin
            grb_s = attr[ATTR_INK_LSB +: 3];
        end else begin
            grb_s = attr[ATTR_PAPER_LSB +: 3];
        end
        if (attr[ATTR_BRIGHT]) begin
            lvl_s = LVL_FULL;
        end else begin
            lvl_s = LVL_NORM;
        end
        green = grb_s[2] ? lvl_s : {CBITS{1'b0}};
        red   = grb_s[1] ? lvl_s : {CBITS{1'b0}};
        blue  = grb_s[0] ? lvl_s : {CBITS{1'b0}};
    end

endmodule

// File: rtl/zx_screen_renderer.sv
// ZX Spectrum screen renderer: beam position in, per-cell prefetch from screen memory,
// registered RGB plus sync delayed by one pixel strobe so they stay aligned.
module zx_screen_renderer import zx_video_pkg::*; #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int SCALE        = 2,
    parameter int ORIGIN_X     = 64,
    parameter int ORIGIN_Y     = 48,
    parameter int CBITS        = 4,
    parameter int FLASH_FRAMES = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             PIX_EN,
    input  logic [9:0]       HPOS,
    input  logic [9:0]       VPOS,
    input  logic             DISPLAY_ON,
    input  logic             HS_IN,
    input  logic             VS_IN,
    input  logic [2:0]       BORDER,
    output logic [12:0]      MEM_ADDR,
    output logic             MEM_RD,
    input  logic [7:0]       MEM_DATA,
    output logic             HS,
    output logic             VS,
    output logic [CBITS-1:0] RED,
    output logic [CBITS-1:0] GREEN,
    output logic [CBITS-1:0] BLUE
);

    localparam int FC_W = $clog2(FLASH_FRAMES + 1);
    localparam logic [9:0] COL0_TRIG_X = 10'(ORIGIN_X - 8 * SCALE);
    localparam logic [CBITS-1:0] LVL_NORM = ~({CBITS{1'b1}} >> 2);

    // Window and address generation
    logic [9:0] hoff_s;
    logic [9:0] voff_s;
    logic       win_line_s;
    logic       win_s;
    logic [7:0] zx_s;
    logic [7:0] zy_s;
    logic [4:0] col_s;
    logic       first_sub_s;
    logic       last_sub_s;
    logic       cell_start_s;
    logic       trig_next_s;
    logic       trig_col0_s;
    logic [4:0] fetch_col_s;
    logic       frame_tick_s;

    // Fetch FSM and prefetched cell
    fetch_state_t state_r;
    logic [12:0]  attr_addr_r;
    logic [7:0]   next_pix_r;
    logic [7:0]   next_attr_r;
    logic         next_valid_r;

    // Cell being displayed
    logic [7:0] shift_r;
    logic [7:0] attr_r;
    logic       cell_valid_r;
    logic [7:0] src_pix_s;
    logic [7:0] cur_attr_s;
    logic       cur_valid_s;

    // Flash timing
    logic [FC_W-1:0] frame_cnt_r;
    logic            flash_phase_r;

    // Colour selection
    logic [CBITS-1:0] cell_red_s;
    logic [CBITS-1:0] cell_green_s;
    logic [CBITS-1:0] cell_blue_s;
    logic [CBITS-1:0] red_s;
    logic [CBITS-1:0] green_s;
    logic [CBITS-1:0] blue_s;

    // Beam position -> ZX coordinates; the 10-bit subtraction wraps so left/top of the window fail the compare.
    always_comb begin
        hoff_s     = HPOS - 10'(ORIGIN_X);
        voff_s     = VPOS - 10'(ORIGIN_Y);
        win_line_s = (voff_s < 10'(ZX_H * SCALE));
        win_s      = win_line_s && (hoff_s < 10'(ZX_W * SCALE)) && (HPOS < 10'(H_ACTIVE));
        if (SCALE == 2) begin
            zx_s        = hoff_s[8:1];
            zy_s        = voff_s[8:1];
            first_sub_s = ~hoff_s[0];
            last_sub_s  = hoff_s[0];
        end else begin
            zx_s        = hoff_s[7:0];
            zy_s        = voff_s[7:0];
            first_sub_s = 1'b1;
            last_sub_s  = 1'b1;
        end
        col_s        = zx_s[7:3];
        cell_start_s = win_s && (zx_s[2:0] == 3'd0) && first_sub_s;
        // Chained fetch only continues from a valid cell, so a line entered without
        // a column-0 prefetch (e.g. after reset) stays black until the next line.
        trig_next_s  = PIX_EN && cell_start_s && (col_s != 5'd31) && next_valid_r;
        trig_col0_s  = PIX_EN && win_line_s && (HPOS == COL0_TRIG_X);
        if (trig_col0_s) begin
            fetch_col_s = 5'd0;
        end else begin
            fetch_col_s = col_s + 5'd1;
        end
        frame_tick_s = PIX_EN && (HPOS == 10'd0) && (VPOS == 10'(V_ACTIVE));
    end

    // Fetch FSM: bitmap byte then attribute byte for the upcoming cell, one read strobe each.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r      <= IDLE;
            MEM_RD       <= 1'b0;
            MEM_ADDR     <= 13'd0;
            attr_addr_r  <= 13'd0;
            next_pix_r   <= 8'd0;
            next_attr_r  <= 8'd0;
            next_valid_r <= 1'b0;
        end else begin
            // The display side consumes the prefetched cell at its first sub-pixel.
            if (PIX_EN && cell_start_s) begin
                next_valid_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (trig_next_s || trig_col0_s) begin
                        state_r     <= RD_PIX;
                        MEM_RD      <= 1'b1;
                        MEM_ADDR    <= zx_pix_addr(zy_s, fetch_col_s);
                        attr_addr_r <= zx_attr_addr(zy_s, fetch_col_s);
                    end else begin
                        MEM_RD <= 1'b0;
                    end
                end
                RD_PIX: begin
                    state_r  <= RD_ATTR;
                    MEM_RD   <= 1'b1;
                    MEM_ADDR <= attr_addr_r;
                end
                RD_ATTR: begin
                    state_r    <= LATCH;
                    MEM_RD     <= 1'b0;
                    next_pix_r <= MEM_DATA;
                end
                LATCH: begin
                    state_r      <= IDLE;
                    MEM_RD       <= 1'b0;
                    next_attr_r  <= MEM_DATA;
                    next_valid_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    MEM_RD  <= 1'b0;
                end
            endcase
        end
    end

    // Current pixel source: at a cell boundary the prefetched cell is used directly.
    always_comb begin
        if (cell_start_s) begin
            src_pix_s   = next_pix_r;
            cur_attr_s  = next_attr_r;
            cur_valid_s = next_valid_r;
        end else begin
            src_pix_s   = shift_r;
            cur_attr_s  = attr_r;
            cur_valid_s = cell_valid_r;
        end
    end

    // Shift register and cell attribute: load on cell start, advance after the last sub-pixel.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            shift_r      <= 8'd0;
            attr_r       <= 8'd0;
            cell_valid_r <= 1'b0;
        end else if (PIX_EN && win_s) begin
            if (last_sub_s) begin
                shift_r <= {src_pix_s[6:0], 1'b0};
            end else begin
                shift_r <= src_pix_s;
            end
            if (cell_start_s) begin
                attr_r       <= next_attr_r;
                cell_valid_r <= next_valid_r;
            end
        end
    end

    // Frame counter: toggles the FLASH phase every FLASH_FRAMES frames.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            frame_cnt_r   <= {FC_W{1'b0}};
            flash_phase_r <= 1'b0;
        end else if (frame_tick_s) begin
            if (frame_cnt_r == FC_W'(FLASH_FRAMES - 1)) begin
                frame_cnt_r   <= {FC_W{1'b0}};
                flash_phase_r <= ~flash_phase_r;
            end else begin
                frame_cnt_r <= frame_cnt_r + FC_W'(1);
            end
        end
    end

    zx_attr_colour #(
        .CBITS (CBITS)
    ) u_attr_colour (
        .attr        (cur_attr_s),
        .pix         (src_pix_s[7]),
        .flash_phase (flash_phase_r),
        .red         (cell_red_s),
        .green       (cell_green_s),
        .blue        (cell_blue_s)
    );

    // Colour select: blanking -> black, outside bitmap -> border, unfetched cell -> black.
    always_comb begin
        if (!DISPLAY_ON) begin
            red_s   = {CBITS{1'b0}};
            green_s = {CBITS{1'b0}};
            blue_s  = {CBITS{1'b0}};
        end else if (!win_s) begin
            green_s = BORDER[2] ? LVL_NORM : {CBITS{1'b0}};
            red_s   = BORDER[1] ? LVL_NORM : {CBITS{1'b0}};
            blue_s  = BORDER[0] ? LVL_NORM : {CBITS{1'b0}};
        end else if (!cur_valid_s) begin
            red_s   = {CBITS{1'b0}};
            green_s = {CBITS{1'b0}};
            blue_s  = {CBITS{1'b0}};
        end else begin
            red_s   = cell_red_s;
            green_s = cell_green_s;
            blue_s  = cell_blue_s;
        end
    end

    // Output registers: colour and sync advance together on each pixel strobe.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RED   <= {CBITS{1'b0}};
            GREEN <= {CBITS{1'b0}};
            BLUE  <= {CBITS{1'b0}};
            HS    <= 1'b0;
            VS    <= 1'b0;
        end else if (PIX_EN) begin
            RED   <= red_s;
            GREEN <= green_s;
            BLUE  <= blue_s;
            HS    <= HS_IN;
            VS    <= VS_IN;
        end
    end

endmodule

// File: tb/tb_zx_screen_renderer.sv
// Self-checking bench for zx_screen_renderer with default parameters.
module tb_zx_screen_renderer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        PIX_EN = 1'b0;
    logic [9:0]  HPOS = 10'd0;
    logic [9:0]  VPOS = 10'd0;
    logic        DISPLAY_ON = 1'b0;
    logic        HS_IN = 1'b0;
    logic        VS_IN = 1'b0;
    logic [2:0]  BORDER = 3'd0;
    logic [12:0] MEM_ADDR;
    logic        MEM_RD;
    logic [7:0]  MEM_DATA;
    logic        HS, VS;
    logic [3:0]  RED, GREEN, BLUE;

    zx_screen_renderer dut (
        .CLK(CLK), .RESET(RESET), .PIX_EN(PIX_EN), .HPOS(HPOS), .VPOS(VPOS),
        .DISPLAY_ON(DISPLAY_ON), .HS_IN(HS_IN), .VS_IN(VS_IN), .BORDER(BORDER),
        .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD), .MEM_DATA(MEM_DATA),
        .HS(HS), .VS(VS), .RED(RED), .GREEN(GREEN), .BLUE(BLUE)
    );

    always #5 CLK = ~CLK;

    // Screen memory with one-cycle synchronous read
    logic [7:0] mem [0:8191];
    logic [7:0] mem_q = 8'd0;
    always @(posedge CLK) if (MEM_RD) mem_q <= mem[MEM_ADDR];
    assign MEM_DATA = mem_q;

    int tests_run = 0;
    int tests_failed = 0;
    int frame_ticks = 0;
    logic [11:0] seen [0:1023];
    logic        rd_log [0:3];
    logic [12:0] addr_log [0:3];

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       de;
        logic       hs;
        logic       vs;
        logic [2:0] border;
        logic [11:0] exp_rgb;
    } vec_t;
    vec_t vecs [0:7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: ZX screen rules in plain arithmetic (2x scale, origin 64/48).
    function automatic logic [11:0] model_rgb(int h, int v, bit de, bit valid);
        int x, y, a_pix, a_attr;
        logic [7:0] pb, ab;
        logic ink, flash;
        logic [2:0] c;
        logic [3:0] lvl;
        if (!de) return 12'h000;
        if (h < 64 || h >= 64 + 512 || v < 48 || v >= 48 + 384)
            return {BORDER[1] ? 4'hC : 4'h0, BORDER[2] ? 4'hC : 4'h0, BORDER[0] ? 4'hC : 4'h0};
        if (!valid) return 12'h000;
        x = (h - 64) / 2;
        y = (v - 48) / 2;
        a_pix  = (y / 64) * 2048 + (y % 8) * 256 + ((y / 8) % 8) * 32 + x / 8;
        a_attr = 6144 + (y / 8) * 32 + x / 8;
        pb = mem[a_pix];
        ab = mem[a_attr];
        flash = ((frame_ticks / 16) % 2) == 1;
        ink = pb[7 - (x % 8)] ^ (ab[7] & flash);
        c = ink ? ab[2:0] : ab[5:3];
        lvl = ab[6] ? 4'hF : 4'hC;
        return {c[1] ? lvl : 4'h0, c[2] ? lvl : 4'h0, c[0] ? lvl : 4'h0};
    endfunction

    // One pixel strobe followed by idle clocks; logs the memory port each clock.
    task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic de,
                       input logic hs, input logic vs);
        @(negedge CLK);
        HPOS = h; VPOS = v; DISPLAY_ON = de; HS_IN = hs; VS_IN = vs; PIX_EN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            PIX_EN = 1'b0;
            rd_log[k] = MEM_RD;
            addr_log[k] = MEM_ADDR;
        end
    endtask

    task automatic step_check(input int h, input int v, input bit rand_de, input bit valid);
        logic de, hs, vs;
        logic [11:0] exp_rgb;
        de = rand_de ? ($urandom_range(0, 15) != 0) : 1'b1;
        hs = 1'($urandom_range(0, 1));
        vs = 1'($urandom_range(0, 1));
        pix(10'(h), 10'(v), de, hs, vs);
        seen[h] = {RED, GREEN, BLUE};
        exp_rgb = model_rgb(h, v, de, valid);
        check($sformatf("pixel h=%0d v=%0d", h, v), {18'd0, RED, GREEN, BLUE, HS, VS},
              {18'd0, exp_rgb, hs, vs});
    endtask

    task automatic sweep(input int v, input int h0, input int h1, input bit rand_de, input bit valid);
        for (int h = h0; h <= h1; h++) step_check(h, v, rand_de, valid);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom_range(0, 255));
        vecs[0] = '{10'd10,  10'd10,  1'b1, 1'b0, 1'b0, 3'b001, 12'h00C};
        vecs[1] = '{10'd10,  10'd10,  1'b0, 1'b1, 1'b0, 3'b001, 12'h000};
        vecs[2] = '{10'd63,  10'd100, 1'b1, 1'b0, 1'b1, 3'b010, 12'hC00};
        vecs[3] = '{10'd576, 10'd100, 1'b1, 1'b1, 1'b1, 3'b100, 12'h0C0};
        vecs[4] = '{10'd64,  10'd47,  1'b1, 1'b0, 1'b0, 3'b111, 12'hCCC};
        vecs[5] = '{10'd300, 10'd432, 1'b1, 1'b1, 1'b0, 3'b011, 12'hC0C};
        vecs[6] = '{10'd639, 10'd479, 1'b0, 1'b0, 1'b1, 3'b111, 12'h000};
        vecs[7] = '{10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 3'b101, 12'h0CC};

        // Reset held mid-line with strobes running: everything stays quiet.
        BORDER = 3'b111;
        repeat (3) @(negedge CLK);
        for (int h = 150; h <= 160; h++) begin
            pix(10'(h), 10'd60, 1'b1, 1'b1, 1'b1);
            check("reset_outputs", {RED, GREEN, BLUE, HS, VS, MEM_RD}, 32'd0);
        end
        @(negedge CLK);
        RESET = 1'b0;
        // Rest of this line has no prefetched cells: black inside the window.
        sweep(60, 161, 620, 1'b0, 1'b0);
        sweep(61, 40, 620, 1'b1, 1'b1);

        // Border / blanking / window edge vectors
        for (int i = 0; i < 8; i++) begin
            BORDER = vecs[i].border;
            pix(vecs[i].h, vecs[i].v, vecs[i].de, vecs[i].hs, vecs[i].vs);
            check($sformatf("vector %0d", i), {18'd0, RED, GREEN, BLUE, HS, VS},
                  {18'd0, vecs[i].exp_rgb, vecs[i].hs, vecs[i].vs});
        end

        // Known cells on the first bitmap line
        BORDER = 3'b001;
        mem[0] = 8'h80; mem[13'h1800] = 8'h07;
        mem[1] = 8'h80; mem[13'h1801] = 8'h42;
        sweep(48, 40, 620, 1'b0, 1'b1);
        check("first_pixel_h64", {20'd0, seen[64]}, {20'd0, 12'hCCC});
        check("first_pixel_h65", {20'd0, seen[65]}, {20'd0, 12'hCCC});
        for (int h = 66; h <= 79; h++) check($sformatf("paper_h%0d", h), {20'd0, seen[h]}, 32'd0);
        check("bright_red_h80", {20'd0, seen[80]}, {20'd0, 12'hF00});

        // Fetch addresses for cell column 3 on line zy=9
        sweep(66, 40, 95, 1'b0, 1'b1);
        step_check(96, 66, 1'b0, 1'b1);
        check("fetch_pix_rd",   {31'd0, rd_log[0]}, 32'd1);
        check("fetch_pix_addr", {19'd0, addr_log[0]}, {19'd0, 13'h0123});
        check("fetch_attr_rd",  {31'd0, rd_log[1]}, 32'd1);
        check("fetch_attr_addr", {19'd0, addr_log[1]}, {19'd0, 13'h1823});
        check("fetch_rd_done",  {31'd0, rd_log[2]}, 32'd0);
        sweep(66, 97, 620, 1'b1, 1'b1);

        // FLASH: white for 16 frames, swapped for the next 16, white again at frame 32
        mem[0] = 8'hFF; mem[13'h1800] = 8'h87;
        for (int f = 0; f <= 32; f++) begin
            sweep(48, 40, 100, 1'b0, 1'b1);
            check($sformatf("flash_frame%0d", f), {20'd0, seen[64]},
                  {20'd0, (f < 16 || f == 32) ? 12'hCCC : 12'h000});
            if (f < 32) begin
                pix(10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
                frame_ticks++;
            end
        end

        // Randomised lines against the reference model
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom_range(0, 255));
        for (int n = 0; n < 10; n++) begin
            BORDER = 3'($urandom_range(0, 7));
            sweep(48 + $urandom_range(0, 383), 40, 620, 1'b1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
